// File: rtl/pulse_cmd_if.sv
`default_nettype none
// ============================================================================
// Module   : pulse_cmd_if
// Brief    : Core-side pulse field writes/issue and released pulse command.
// Revision : 1.0 - initial release
// ============================================================================
interface pulse_cmd_if #(
   parameter int PHASE_WIDTH    = 17,
   parameter int FREQ_WIDTH     = 9,
   parameter int AMP_WIDTH      = 16,
   parameter int CFG_WIDTH      = 4,
   parameter int ENV_WORD_WIDTH = 24,
   parameter int TIME_WIDTH     = 32
);
   logic                      wr_phase;
   logic [PHASE_WIDTH-1:0]    phase_in;
   logic                      wr_freq;
   logic [FREQ_WIDTH-1:0]     freq_in;
   logic                      wr_amp;
   logic [AMP_WIDTH-1:0]      amp_in;
   logic                      wr_env;
   logic [ENV_WORD_WIDTH-1:0] env_in;
   logic                      wr_cfg;
   logic [CFG_WIDTH-1:0]      cfg_in;
   logic                      issue;
   logic [TIME_WIDTH-1:0]     issue_time;

   logic [PHASE_WIDTH-1:0]    phase;
   logic [FREQ_WIDTH-1:0]     freq;
   logic [AMP_WIDTH-1:0]      amp;
   logic [ENV_WORD_WIDTH-1:0] env_word;
   logic [CFG_WIDTH-1:0]      cfg;
   logic                      cstrobe;

   modport master (
      output wr_phase, phase_in, wr_freq, freq_in, wr_amp, amp_in,
             wr_env, env_in, wr_cfg, cfg_in, issue, issue_time,
      input  phase, freq, amp, env_word, cfg, cstrobe
   );

   modport slave (
      input  wr_phase, phase_in, wr_freq, freq_in, wr_amp, amp_in,
             wr_env, env_in, wr_cfg, cfg_in, issue, issue_time,
      output phase, freq, amp, env_word, cfg, cstrobe
   );
endinterface
`default_nettype wire

// File: rtl/pulse_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : pulse_cmd_queue
// Brief    : Shadowed pulse fields queued with a timestamp, released on time.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_cmd_queue #(
   parameter int PHASE_WIDTH    = 17,
   parameter int FREQ_WIDTH     = 9,
   parameter int AMP_WIDTH      = 16,
   parameter int CFG_WIDTH      = 4,
   parameter int ENV_WORD_WIDTH = 24,
   parameter int TIME_WIDTH     = 32,
   parameter int DEPTH          = 8
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              tref_rst,
   input  wire logic              flush,
   input  wire logic              clear_err,
   pulse_cmd_if.slave             cmd,
   output logic [TIME_WIDTH-1:0]  time_now,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   output logic                   late
);
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   typedef struct packed {
      logic [PHASE_WIDTH-1:0]    phase;
      logic [FREQ_WIDTH-1:0]     freq;
      logic [AMP_WIDTH-1:0]      amp;
      logic [ENV_WORD_WIDTH-1:0] env;
      logic [CFG_WIDTH-1:0]      cfg;
   } fields_t;

   typedef struct packed {
      fields_t               f;
      logic [TIME_WIDTH-1:0] stamp;
   } entry_t;

   logic [TIME_WIDTH-1:0]     r_time;
   logic [PHASE_WIDTH-1:0]    r_phase_sh;
   logic [FREQ_WIDTH-1:0]     r_freq_sh;
   logic [AMP_WIDTH-1:0]      r_amp_sh;
   logic [ENV_WORD_WIDTH-1:0] r_env_sh;
   logic [CFG_WIDTH-1:0]      r_cfg_sh;
   entry_t                    r_mem [DEPTH];
   logic [c_ptr_w-1:0]        r_wr_ptr;
   logic [c_ptr_w-1:0]        r_rd_ptr;
   logic [c_cnt_w-1:0]        r_count;
   fields_t                   r_out;
   logic                      r_cstrobe;
   logic                      r_overflow;
   logic                      r_late;

   entry_t                    w_snap;
   entry_t                    w_head;
   logic [TIME_WIDTH-1:0]     w_delta;
   logic                      w_full;
   logic                      w_push;
   logic                      w_drop;
   logic                      w_pop;
   logic                      w_late_rel;

   // Snapshot bypasses the shadows so a same-cycle write is captured.
   always_comb begin
      w_snap.f.phase = cmd.wr_phase ? cmd.phase_in : r_phase_sh;
      w_snap.f.freq  = cmd.wr_freq  ? cmd.freq_in  : r_freq_sh;
      w_snap.f.amp   = cmd.wr_amp   ? cmd.amp_in   : r_amp_sh;
      w_snap.f.env   = cmd.wr_env   ? cmd.env_in   : r_env_sh;
      w_snap.f.cfg   = cmd.wr_cfg   ? cmd.cfg_in   : r_cfg_sh;
      w_snap.stamp   = cmd.issue_time;
      w_head         = r_mem[r_rd_ptr];
      w_delta        = w_head.stamp - r_time;
      w_full         = (r_count == c_cnt_w'(DEPTH));
      w_push         = cmd.issue && !w_full && !flush;
      w_drop         = cmd.issue && w_full && !flush;
      // A negative distance (MSB set) means the stamp has already passed.
      w_pop          = (r_count != '0) && ((w_delta == '0) || w_delta[TIME_WIDTH-1]);
      w_late_rel     = w_pop && w_delta[TIME_WIDTH-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase_sh <= '0;
         r_freq_sh  <= '0;
         r_amp_sh   <= '0;
         r_env_sh   <= '0;
         r_cfg_sh   <= '0;
      end else begin
         if (cmd.wr_phase) r_phase_sh <= cmd.phase_in;
         if (cmd.wr_freq)  r_freq_sh  <= cmd.freq_in;
         if (cmd.wr_amp)   r_amp_sh   <= cmd.amp_in;
         if (cmd.wr_env)   r_env_sh   <= cmd.env_in;
         if (cmd.wr_cfg)   r_cfg_sh   <= cmd.cfg_in;
      end
   end

   // Storage needs no reset: entries are only read while count is non-zero.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_snap;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_time     <= '0;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_out      <= '0;
         r_cstrobe  <= 1'b0;
         r_overflow <= 1'b0;
         r_late     <= 1'b0;
      end else begin
         r_time    <= tref_rst ? '0 : r_time + 1'b1;
         r_cstrobe <= w_pop;
         if (w_pop) r_out <= w_head.f;

         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
         end

         if (w_drop)         r_overflow <= 1'b1;
         else if (clear_err) r_overflow <= 1'b0;

         if (w_late_rel)     r_late <= 1'b1;
         else if (clear_err) r_late <= 1'b0;
      end
   end

   assign cmd.phase    = r_out.phase;
   assign cmd.freq     = r_out.freq;
   assign cmd.amp      = r_out.amp;
   assign cmd.env_word = r_out.env;
   assign cmd.cfg      = r_out.cfg;
   assign cmd.cstrobe  = r_cstrobe;
   assign time_now     = r_time;
   assign count        = r_count;
   assign full         = w_full;
   assign empty        = (r_count == '0);
   assign overflow     = r_overflow;
   assign late         = r_late;
endmodule
`default_nettype wire

// File: tb/tb_pulse_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_cmd_queue
// Brief    : Vector table plus scoreboard of expected releases for the queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_cmd_queue;
   localparam int PW = 17;
   localparam int FW = 9;
   localparam int AW = 16;
   localparam int CW = 4;
   localparam int EW = 24;
   localparam int TW = 12;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          tref_rst = 1'b0;
   logic          flush = 1'b0;
   logic          clear_err = 1'b0;
   logic [TW-1:0] time_now;
   logic [3:0]    count;
   logic          full, empty, overflow, late;

   pulse_cmd_if #(.PHASE_WIDTH(PW), .FREQ_WIDTH(FW), .AMP_WIDTH(AW), .CFG_WIDTH(CW),
                  .ENV_WORD_WIDTH(EW), .TIME_WIDTH(TW)) cif ();

   pulse_cmd_queue #(.PHASE_WIDTH(PW), .FREQ_WIDTH(FW), .AMP_WIDTH(AW), .CFG_WIDTH(CW),
                     .ENV_WORD_WIDTH(EW), .TIME_WIDTH(TW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .tref_rst(tref_rst), .flush(flush), .clear_err(clear_err),
      .cmd(cif), .time_now(time_now), .count(count), .full(full), .empty(empty),
      .overflow(overflow), .late(late)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] ph;
      logic [FW-1:0] fr;
      logic [AW-1:0] am;
      logic [EW-1:0] en;
      logic [CW-1:0] cf;
      logic [TW-1:0] t;
      logic          lt;
   } exp_t;

   typedef struct {
      logic [TW-1:0] at;
      logic [4:0]    wm;
      logic [PW-1:0] ph;
      logic [FW-1:0] fr;
      logic [AW-1:0] am;
      logic [EW-1:0] en;
      logic [CW-1:0] cf;
      logic [TW-1:0] it;
      logic [TW-1:0] st;
      logic          lt;
      logic          clr;
      logic          drn;
   } vec_t;

   exp_t          sb[$];
   vec_t          vt[7];
   int            n_tests = 0;
   int            n_fail  = 0;
   logic [TW-1:0] m_time;
   logic [PW-1:0] sh_ph;
   logic [FW-1:0] sh_fr;
   logic [AW-1:0] sh_am;
   logic [EW-1:0] sh_en;
   logic [CW-1:0] sh_cf;

   always @(posedge clk or posedge rst) begin
      if (rst)           m_time <= '0;
      else if (tref_rst) m_time <= '0;
      else               m_time <= m_time + 1'b1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && cif.cstrobe) begin
         if (sb.size() == 0) begin
            chk("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("strobe_time", time_now, e.t);
            chk("rel_phase", cif.phase, e.ph);
            chk("rel_freq", cif.freq, e.fr);
            chk("rel_amp", cif.amp, e.am);
            chk("rel_env", cif.env_word, e.en);
            chk("rel_cfg", cif.cfg, e.cf);
            chk("rel_late", late, e.lt);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_until(input logic [TW-1:0] t);
      int n = 0;
      while (m_time != t && n < 8000) begin
         step();
         n++;
      end
      chk("wait_until", m_time, t);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 3000) begin
         step();
         n++;
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic do_issue(input logic [4:0] wm, input logic [PW-1:0] ph, input logic [FW-1:0] fr,
                           input logic [AW-1:0] am, input logic [EW-1:0] en, input logic [CW-1:0] cf,
                           input logic [TW-1:0] it, input logic exp_rel, input logic [TW-1:0] st,
                           input logic lt, input logic clr);
      exp_t e;
      cif.wr_phase = wm[4]; cif.phase_in = ph;
      cif.wr_freq  = wm[3]; cif.freq_in  = fr;
      cif.wr_amp   = wm[2]; cif.amp_in   = am;
      cif.wr_env   = wm[1]; cif.env_in   = en;
      cif.wr_cfg   = wm[0]; cif.cfg_in   = cf;
      cif.issue    = 1'b1;  cif.issue_time = it;
      clear_err    = clr;
      if (wm[4]) sh_ph = ph;
      if (wm[3]) sh_fr = fr;
      if (wm[2]) sh_am = am;
      if (wm[1]) sh_en = en;
      if (wm[0]) sh_cf = cf;
      if (exp_rel) begin
         e.ph = sh_ph; e.fr = sh_fr; e.am = sh_am; e.en = sh_en; e.cf = sh_cf;
         e.t  = st;    e.lt = lt;
         sb.push_back(e);
      end
      step();
      cif.wr_phase = 1'b0; cif.wr_freq = 1'b0; cif.wr_amp = 1'b0;
      cif.wr_env   = 1'b0; cif.wr_cfg  = 1'b0; cif.issue  = 1'b0;
      clear_err    = 1'b0;
   endtask

   task automatic issue_plain(input logic [TW-1:0] it, input logic exp_rel,
                              input logic [TW-1:0] st, input logic lt);
      do_issue(5'b0, '0, '0, '0, '0, '0, it, exp_rel, st, lt, 1'b0);
   endtask

   task automatic pulse_clear();
      clear_err = 1'b1;
      step();
      clear_err = 1'b0;
   endtask

   initial begin
      vt[0] = '{at:12'd10,  wm:5'b11111, ph:17'h1ABCD, fr:9'h55, am:16'h7FFF, en:24'h010020, cf:4'h9,
                it:12'd100, st:12'd101, lt:1'b0, clr:1'b0, drn:1'b1};
      vt[1] = '{at:12'd120, wm:5'b00100, ph:17'h0, fr:9'h0, am:16'h1, en:24'h0, cf:4'h0,
                it:12'd150, st:12'd151, lt:1'b0, clr:1'b0, drn:1'b0};
      vt[2] = '{at:12'd121, wm:5'b00100, ph:17'h0, fr:9'h0, am:16'h2, en:24'h0, cf:4'h0,
                it:12'd150, st:12'd152, lt:1'b1, clr:1'b0, drn:1'b0};
      vt[3] = '{at:12'd122, wm:5'b00100, ph:17'h0, fr:9'h0, am:16'h3, en:24'h0, cf:4'h0,
                it:12'd160, st:12'd161, lt:1'b1, clr:1'b0, drn:1'b1};
      vt[4] = '{at:12'd200, wm:5'b00000, ph:17'h0, fr:9'h0, am:16'h0, en:24'h0, cf:4'h0,
                it:12'd10,  st:12'd202, lt:1'b1, clr:1'b1, drn:1'b1};
      vt[5] = '{at:12'd220, wm:5'b00100, ph:17'h0, fr:9'h0, am:16'h1234, en:24'h0, cf:4'h0,
                it:12'd230, st:12'd231, lt:1'b0, clr:1'b1, drn:1'b1};
      vt[6] = '{at:12'd240, wm:5'b00000, ph:17'h0, fr:9'h0, am:16'h0, en:24'h0, cf:4'h0,
                it:12'd250, st:12'd251, lt:1'b0, clr:1'b0, drn:1'b1};

      cif.wr_phase = 1'b0; cif.wr_freq = 1'b0; cif.wr_amp = 1'b0; cif.wr_env = 1'b0;
      cif.wr_cfg = 1'b0; cif.issue = 1'b0; cif.phase_in = '0; cif.freq_in = '0;
      cif.amp_in = '0; cif.env_in = '0; cif.cfg_in = '0; cif.issue_time = '0;
      sh_ph = '0; sh_fr = '0; sh_am = '0; sh_en = '0; sh_cf = '0;

      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_time", time_now, 0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_late", late, 0);
      chk("rst_strobe", cif.cstrobe, 0);
      chk("rst_amp", cif.amp, 0);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) begin
         wait_until(vt[i].at);
         do_issue(vt[i].wm, vt[i].ph, vt[i].fr, vt[i].am, vt[i].en, vt[i].cf,
                  vt[i].it, 1'b1, vt[i].st, vt[i].lt, vt[i].clr);
         if (vt[i].drn) drain();
      end

      // Overflow: DEPTH+1 issues, the last one dropped and never released.
      wait_until(12'd300);
      for (int k = 0; k < D + 1; k++)
         issue_plain(12'd1000, (k < D) ? 1'b1 : 1'b0, TW'(1001 + k), (k != 0) ? 1'b1 : 1'b0);
      chk("ovf_count", count, D);
      chk("ovf_full", full, 1);
      chk("ovf_flag", overflow, 1);
      chk("ovf_empty", empty, 0);
      pulse_clear();
      chk("ovf_cleared", overflow, 0);
      wait_until(12'd1000);
      issue_plain(12'd1000, 1'b0, '0, 1'b0);
      chk("ovf_full_pop", overflow, 1);
      chk("ovf_full_pop_count", count, D - 1);
      pulse_clear();
      chk("ovf_cleared2", overflow, 0);
      drain();
      chk("late_sticky", late, 1);
      chk("drained_count", count, 0);
      chk("drained_empty", empty, 1);
      pulse_clear();
      chk("late_cleared", late, 0);

      // Time base restart, then releases straddling the counter wrap.
      tref_rst = 1'b1;
      step();
      tref_rst = 1'b0;
      chk("tref_zero", time_now, 0);
      wait_until(12'd4086);
      issue_plain(12'd4091, 1'b1, 12'd4092, 1'b0);
      wait_until(12'd4088);
      issue_plain(12'd3, 1'b1, 12'd4, 1'b0);
      drain();
      chk("wrap_late", late, 0);

      // Flush with a release in flight and a concurrent issue.
      wait_until(12'd20);
      issue_plain(12'd40, 1'b1, 12'd41, 1'b0);
      for (int k = 0; k < 3; k++) issue_plain(12'd900, 1'b0, '0, 1'b0);
      chk("q4_count", count, 4);
      wait_until(12'd40);
      flush = 1'b1;
      issue_plain(12'd41, 1'b0, '0, 1'b0);
      flush = 1'b0;
      chk("flush_count", count, 0);
      chk("flush_empty", empty, 1);
      chk("flush_no_ovf", overflow, 0);
      drain();
      wait_until(12'd45);
      issue_plain(12'd900, 1'b0, '0, 1'b0);
      issue_plain(12'd900, 1'b0, '0, 1'b0);
      tref_rst = 1'b1;
      step();
      tref_rst = 1'b0;
      chk("tref2_time", time_now, 0);
      chk("tref2_count", count, 2);

      // Asynchronous reset mid-queue.
      #2 rst = 1'b1;
      #1;
      chk("arst_time", time_now, 0);
      chk("arst_count", count, 0);
      chk("arst_empty", empty, 1);
      chk("arst_phase", cif.phase, 0);
      chk("arst_amp", cif.amp, 0);
      chk("arst_env", cif.env_word, 0);
      chk("arst_cfg", cif.cfg, 0);
      sh_ph = '0; sh_fr = '0; sh_am = '0; sh_en = '0; sh_cf = '0;
      @(negedge clk);
      rst = 1'b0;
      step();
      wait_until(12'd20);
      issue_plain(12'd30, 1'b1, 12'd31, 1'b0);
      drain();
      wait_until(12'd950);
      chk("no_stale", sb.size(), 0);
      chk("end_count", count, 0);
      chk("end_empty", empty, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
